// File: rtl/bram_rd_streamer.sv
// bram_rd_streamer: streams a burst of words out of one read port of a dual-port block RAM.
// Latency: command accept -> first m_valid 3 cycles later (address reg, RAM read, capture); then 1 beat/clk.
// Backpressure: m_ready low holds the head beat stable; reads issue only when the 2-entry buffer will have room.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   cmd_valid/cmd_ready          burst command handshake (cmd_addr start, cmd_len beats 0..2**ADDR)
//   mem_addr, mem_dout           RAM read port (registered address, 1-cycle read latency)
//   m_valid/m_ready/m_data/m_last output stream, m_last on the final beat of a burst
//   done                         one-cycle pulse when a burst completes (or is aborted)
//   busy                         high from command accept until completion
//   abort                        only with BRAM_RD_STREAMER_ABORT_EN defined: cancels the active burst
module bram_rd_streamer #(
  parameter int DATA = 72,
  parameter int ADDR = 10
) (
  input  logic            clk,
  input  logic            rst,
`ifdef BRAM_RD_STREAMER_ABORT_EN
  input  logic            abort,
`endif
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [ADDR-1:0] cmd_addr,
  input  logic [ADDR:0]   cmd_len,
  output logic [ADDR-1:0] mem_addr,
  input  logic [DATA-1:0] mem_dout,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DATA-1:0] m_data,
  output logic            m_last,
  output logic            done,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic            last;
    logic [DATA-1:0] dat;
  } beat_t;

  localparam logic [ADDR-1:0] ADDR_ONE = ADDR'(1);
  localparam logic [ADDR:0]   REM_ONE  = (ADDR+1)'(1);

  state_t          state_q, state_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [ADDR:0]   rem_q, rem_d;
  logic            infl_q, infl_d;
  logic            infl_last_q, infl_last_d;
  logic [1:0]      occ_q, occ_d;
  beat_t           buf0_q, buf0_d;
  beat_t           buf1_q, buf1_d;
  logic            done_q, done_d;

  logic            cmd_fire;
  logic            pop;
  logic            issue;
  logic            abort_fire;
  logic [2:0]      occ_after;
  logic [1:0]      wr_idx;
  beat_t           cap_beat;

  // The address counter is itself the RAM address register: the RAM samples
  // the current address every cycle, but only cycles flagged as issues are
  // followed by a capture.
  assign mem_addr  = addr_q;
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign cmd_fire  = cmd_valid && cmd_ready;

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf0_q.dat;
  assign m_last    = m_valid && buf0_q.last;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

  assign pop       = m_valid && m_ready;

`ifdef BRAM_RD_STREAMER_ABORT_EN
  assign abort_fire = abort && (state_q != IDLE);
`else
  assign abort_fire = 1'b0;
`endif

  // Occupancy at the end of this cycle once the in-flight word lands and any
  // pop is taken; a new read is only legal if its data will still fit.
  assign occ_after = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
  assign issue     = (state_q == RUN) && (rem_q != '0) && (occ_after < 3'd2) && !abort_fire;

  // Tail slot for the captured word, after accounting for a same-cycle pop.
  assign wr_idx    = occ_q - {1'b0, pop};

  always_comb begin
    cap_beat      = '0;
    cap_beat.last = infl_last_q;
    cap_beat.dat  = mem_dout;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    done_d      = 1'b0;
    occ_d       = occ_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_len != '0) begin
            addr_d  = cmd_addr;
            rem_d   = cmd_len;
            state_d = RUN;
          end else begin
            // Empty burst: nothing to read, just acknowledge completion.
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_ONE;
          rem_d       = rem_q - REM_ONE;
          infl_d      = 1'b1;
          infl_last_d = (rem_q == REM_ONE);
          if (rem_q == REM_ONE) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && buf0_q.last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Two-entry buffer, head in slot 0. A pop shifts slot 1 forward; a
    // capture then lands in the first free slot after that shift.
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (infl_q) begin
      if (wr_idx == 2'd0) begin
        buf0_d = cap_beat;
      end else begin
        buf1_d = cap_beat;
      end
    end
    occ_d = occ_q + {1'b0, infl_q} - {1'b0, pop};

    if (abort_fire) begin
      state_d     = IDLE;
      rem_d       = '0;
      infl_d      = 1'b0;
      infl_last_d = 1'b0;
      occ_d       = 2'd0;
      done_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_bram_rd_streamer.sv
// tb_bram_rd_streamer: directed bench for bram_rd_streamer with a behavioural RAM (mem[i] = i).
// Latency: n/a (bench).
// Backpressure: m_ready driven from a fixed pattern in the backpressure scenario.
module tb_bram_rd_streamer;

  localparam int DATA = 72;
  localparam int ADDR = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [ADDR-1:0] cmd_addr = '0;
  logic [ADDR:0]   cmd_len = '0;
  logic [ADDR-1:0] mem_addr;
  logic [DATA-1:0] mem_dout;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [DATA-1:0] m_data;
  logic            m_last;
  logic            done;
  logic            busy;
`ifdef BRAM_RD_STREAMER_ABORT_EN
  logic            abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [DATA-1:0] ram [0:(1<<ADDR)-1];
  logic [15:0]     pat = 16'b1011_0010_1101_0110;

  logic [DATA-1:0] got_data[$];
  bit              got_last[$];
  int first_valid, done_cnt, done_cyc, stall_err, busy_cnt, rdy_busy_err, valid_cnt;

  bram_rd_streamer #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef BRAM_RD_STREAMER_ABORT_EN
    .abort     (abort),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1 << ADDR); i++) ram[i] = DATA'(i);
  end

  always @(posedge clk) mem_dout <= ram[mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached without finishing, required finish before 200000", $time);
    $fatal(1, "bench timeout");
  end

  // Presents a command until accepted (bounded); returns just after the accept edge.
  task automatic send_cmd(input logic [ADDR-1:0] a, input logic [ADDR:0] l, output bit accepted);
    int tries;
    accepted  = 1'b0;
    tries     = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    while (!accepted && tries < 20) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) accepted = 1'b1;
      @(posedge clk); #1;
      tries++;
    end
    cmd_valid = 1'b0;
  endtask

  // Observes n cycles of the stream, recording beats and events; use_pat drives m_ready from pat.
  task automatic run_stream(input int n, input bit use_pat);
    bit              prev_stall;
    logic [DATA-1:0] pd;
    logic            pl;
    got_data.delete();
    got_last.delete();
    first_valid = -1; done_cnt = 0; done_cyc = -1; stall_err = 0;
    busy_cnt = 0; rdy_busy_err = 0; valid_cnt = 0;
    prev_stall = 1'b0; pd = '0; pl = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = k;
      end
      if (prev_stall && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) stall_err++;
      if (done === 1'b1) begin done_cnt++; done_cyc = k; end
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && cmd_ready !== 1'b0) rdy_busy_err++;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        got_data.push_back(m_data);
        got_last.push_back(m_last);
      end
      prev_stall = (m_valid === 1'b1) && (m_ready !== 1'b1);
      pd = m_data;
      pl = m_last;
      @(posedge clk); #1;
      m_ready = use_pat ? pat[k % 16] : 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); end
    checks++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin errors++; $display("FAIL reset_stream got valid %b last %b exp 0 0", m_valid, m_last); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b %b exp 0 0", busy, done); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %0d exp 0", mem_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_cmd_ready got %b exp 1", cmd_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit acc;
    m_ready = 1'b1;
    send_cmd(10'd5, 11'd4, acc);
    checks++; if (!acc) begin errors++; $display("FAIL basic_accept got 0 exp 1"); end
    run_stream(10, 1'b0);
    checks++; if (got_data.size() != 4) begin errors++; $display("FAIL basic_count got %0d exp 4", got_data.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got_data.size()) begin
        checks++;
        if (got_data[i] !== DATA'(5 + i) || got_last[i] !== (i == 3)) begin
          errors++; $display("FAIL basic_beat%0d got %0d/%b exp %0d/%b", i, got_data[i], got_last[i], 5 + i, (i == 3));
        end
      end
    end
    checks++; if (first_valid != 3) begin errors++; $display("FAIL basic_latency got %0d exp 3", first_valid); end
    checks++; if (done_cnt != 1 || done_cyc != 7) begin errors++; $display("FAIL basic_done got cnt %0d cyc %0d exp 1 7", done_cnt, done_cyc); end
    checks++; if (busy_cnt != 6 || rdy_busy_err != 0) begin errors++; $display("FAIL basic_busy got %0d/%0d exp 6/0", busy_cnt, rdy_busy_err); end
  endtask

  task automatic test_wrap();
    bit acc;
    m_ready = 1'b1;
    send_cmd(10'd1022, 11'd4, acc);
    checks++; if (!acc) begin errors++; $display("FAIL wrap_accept got 0 exp 1"); end
    run_stream(10, 1'b0);
    checks++; if (got_data.size() != 4) begin errors++; $display("FAIL wrap_count got %0d exp 4", got_data.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got_data.size()) begin
        checks++;
        if (got_data[i] !== DATA'((1022 + i) % 1024) || got_last[i] !== (i == 3)) begin
          errors++; $display("FAIL wrap_beat%0d got %0d/%b exp %0d/%b", i, got_data[i], got_last[i], (1022 + i) % 1024, (i == 3));
        end
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL wrap_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    bit acc;
    int bad;
    m_ready = 1'b0;
    send_cmd(10'd0, 11'd16, acc);
    checks++; if (!acc) begin errors++; $display("FAIL bp_accept got 0 exp 1"); end
    run_stream(90, 1'b1);
    checks++; if (got_data.size() != 16) begin errors++; $display("FAIL bp_count got %0d exp 16", got_data.size()); end
    bad = 0;
    for (int i = 0; i < got_data.size(); i++) begin
      if (got_data[i] !== DATA'(i) || got_last[i] !== (i == 15)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_order got %0d wrong beats exp 0", bad); end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable got %0d changes while stalled exp 0", stall_err); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done got %0d exp 1", done_cnt); end
    checks++; if (rdy_busy_err != 0 || busy_cnt == 0) begin errors++; $display("FAIL bp_cmd_ready got %0d ready-while-busy, busy %0d cycles exp 0, >0", rdy_busy_err, busy_cnt); end
  endtask

  task automatic test_len0();
    bit acc;
    m_ready = 1'b1;
    send_cmd(10'd7, 11'd0, acc);
    checks++; if (!acc) begin errors++; $display("FAIL len0_accept got 0 exp 1"); end
    run_stream(5, 1'b0);
    checks++; if (valid_cnt != 0) begin errors++; $display("FAIL len0_valid got %0d exp 0", valid_cnt); end
    checks++; if (done_cnt != 1 || done_cyc != 1) begin errors++; $display("FAIL len0_done got cnt %0d cyc %0d exp 1 1", done_cnt, done_cyc); end
    checks++; if (busy_cnt != 0) begin errors++; $display("FAIL len0_busy got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_reset_mid();
    bit acc;
    int beats, cyc;
    m_ready = 1'b1;
    send_cmd(10'd0, 11'd8, acc);
    checks++; if (!acc) begin errors++; $display("FAIL rstmid_accept got 0 exp 1"); end
    beats = 0; cyc = 0;
    while (beats < 3 && cyc < 20) begin
      @(negedge clk);
      if (m_valid === 1'b1 && m_ready === 1'b1) beats++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (beats != 3) begin errors++; $display("FAIL rstmid_beats got %0d exp 3", beats); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rstmid_cmd_ready_in_rst got %b exp 0", cmd_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_state got v%b b%b d%b exp 0 0 0", m_valid, busy, done); end
    checks++; if (cmd_ready !== 1'b1 || mem_addr !== '0) begin errors++; $display("FAIL rstmid_ready_addr got %b/%0d exp 1/0", cmd_ready, mem_addr); end
    @(posedge clk); #1;
    run_stream(4, 1'b0);
    checks++; if (valid_cnt != 0 || done_cnt != 0) begin errors++; $display("FAIL rstmid_quiet got valid %0d done %0d exp 0 0", valid_cnt, done_cnt); end
    send_cmd(10'd0, 11'd2, acc);
    checks++; if (!acc) begin errors++; $display("FAIL rstmid_accept2 got 0 exp 1"); end
    run_stream(8, 1'b0);
    checks++;
    if (got_data.size() != 2) begin
      errors++; $display("FAIL rstmid_count got %0d exp 2", got_data.size());
    end else if (got_data[0] !== DATA'(0) || got_data[1] !== DATA'(1) || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
      errors++; $display("FAIL rstmid_data got %0d/%b %0d/%b exp 0/0 1/1", got_data[0], got_last[0], got_data[1], got_last[1]);
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL rstmid_done got %0d exp 1", done_cnt); end
  endtask

`ifdef BRAM_RD_STREAMER_ABORT_EN
  task automatic test_abort();
    bit acc;
    int beats, cyc;
    m_ready = 1'b1;
    send_cmd(10'd0, 11'd10, acc);
    checks++; if (!acc) begin errors++; $display("FAIL abort_accept got 0 exp 1"); end
    beats = 0; cyc = 0;
    while (beats < 2 && cyc < 20) begin
      @(negedge clk);
      if (m_valid === 1'b1 && m_ready === 1'b1) beats++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (beats != 2) begin errors++; $display("FAIL abort_beats got %0d exp 2", beats); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL abort_flush got v%b d%b exp 0 1", m_valid, done); end
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle got r%b b%b exp 1 0", cmd_ready, busy); end
    @(posedge clk); #1;
    run_stream(6, 1'b0);
    checks++; if (valid_cnt != 0 || done_cnt != 0) begin errors++; $display("FAIL abort_quiet got valid %0d done %0d exp 0 0", valid_cnt, done_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0();
    test_reset_mid();
`ifdef BRAM_RD_STREAMER_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
